// File: rtl/shift_operand_ctrl.sv
`default_nettype none
// ============================================================================
// shift_operand_ctrl: decodes operand2 and sequences the barrel shifter.
// Revision 1.0
// ============================================================================
module shift_operand_ctrl #(
    parameter int RS_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_imm,
    input  logic [11:0] req_operand,
    input  logic [31:0] req_rm_data,
    input  logic        req_carry_in,
    output logic        rs_rd_en,
    output logic [3:0]  rs_addr,
    input  logic [31:0] rs_rd_data,
    output logic [31:0] sh_data,
    output logic [7:0]  sh_num,
    output logic [2:0]  sh_op,
    output logic        sh_carry,
    input  logic [31:0] sh_out,
    input  logic        sh_carry_out,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_carry
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RSRD   = 3'd1,
        RSWAIT = 3'd2,
        SHIFT  = 3'd3,
        RESP   = 3'd4
    } state_t;

    localparam logic [1:0] c_CNT_INIT = 2'(RS_LAT - 1);

    state_t      state_q, state_d;
    logic [31:0] sh_data_q, sh_data_d;
    logic [7:0]  sh_num_q, sh_num_d;
    logic [2:0]  sh_op_q, sh_op_d;
    logic        sh_carry_q, sh_carry_d;
    logic [3:0]  rs_addr_q, rs_addr_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        zero_q, zero_d;
    logic        regform_q, regform_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_carry_q, rsp_carry_d;

    logic [7:0]  w_amt;
    logic        w_ror_wrap;
    logic        w_accept;
    logic        w_unused;

    assign w_amt      = rs_rd_data[7:0];
    // Non-zero rotate by a multiple of 32 must still reach the shifter as 32.
    assign w_ror_wrap = (sh_op_q[2:1] == 2'b11) && (w_amt != 8'd0) && (w_amt[4:0] == 5'd0);
    assign w_unused   = ^{req_operand[3:0], rs_rd_data[31:8]};

    assign req_ready = rst_n && !flush && (state_q == IDLE);
    assign w_accept  = req_valid && req_ready;
    assign rs_rd_en  = (state_q == RSRD);
    assign rsp_valid = (state_q == RESP);
    assign rs_addr   = rs_addr_q;
    assign sh_data   = sh_data_q;
    assign sh_num    = sh_num_q;
    assign sh_op     = sh_op_q;
    assign sh_carry  = sh_carry_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_carry = rsp_carry_q;

    always_comb begin
        state_d     = state_q;
        sh_data_d   = sh_data_q;
        sh_num_d    = sh_num_q;
        sh_op_d     = sh_op_q;
        sh_carry_d  = sh_carry_q;
        rs_addr_d   = rs_addr_q;
        cnt_d       = cnt_q;
        zero_d      = zero_q;
        regform_d   = regform_q;
        rsp_data_d  = rsp_data_q;
        rsp_carry_d = rsp_carry_q;

        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    sh_carry_d = req_carry_in;
                    regform_d  = 1'b0;
                    state_d    = SHIFT;
                    if (req_imm) begin
                        sh_data_d = {24'b0, req_operand[7:0]};
                        sh_op_d   = 3'b111;
                        sh_num_d  = {3'b0, req_operand[11:8], 1'b0};
                        zero_d    = (req_operand[11:8] == 4'd0);
                    end else begin
                        sh_data_d = req_rm_data;
                        sh_op_d   = {req_operand[6:5], req_operand[4]};
                        if (!req_operand[4]) begin
                            sh_num_d = {3'b0, req_operand[11:7]};
                            // Only LSL #0 is a true zero shift; other #0 codes are LSR/ASR #32 and RRX.
                            zero_d   = (req_operand[6:5] == 2'b00) && (req_operand[11:7] == 5'd0);
                        end else begin
                            rs_addr_d = req_operand[11:8];
                            regform_d = 1'b1;
                            state_d   = RSRD;
                        end
                    end
                end
            end
            RSRD: begin
                cnt_d   = c_CNT_INIT;
                state_d = RSWAIT;
            end
            RSWAIT: begin
                if (cnt_q == 2'd0) begin
                    sh_num_d = w_ror_wrap ? 8'd32 : w_amt;
                    zero_d   = (w_amt == 8'd0);
                    state_d  = SHIFT;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            SHIFT: begin
                rsp_data_d  = (regform_q && zero_q) ? sh_data_q : sh_out;
                rsp_carry_d = zero_q ? sh_carry_q : sh_carry_out;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sh_data_q   <= 32'd0;
            sh_num_q    <= 8'd0;
            sh_op_q     <= 3'd0;
            sh_carry_q  <= 1'b0;
            rs_addr_q   <= 4'd0;
            cnt_q       <= 2'd0;
            zero_q      <= 1'b0;
            regform_q   <= 1'b0;
            rsp_data_q  <= 32'd0;
            rsp_carry_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_data_q   <= sh_data_d;
            sh_num_q    <= sh_num_d;
            sh_op_q     <= sh_op_d;
            sh_carry_q  <= sh_carry_d;
            rs_addr_q   <= rs_addr_d;
            cnt_q       <= cnt_d;
            zero_q      <= zero_d;
            regform_q   <= regform_d;
            rsp_data_q  <= rsp_data_d;
            rsp_carry_q <= rsp_carry_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shift_operand_ctrl.sv
`default_nettype none
// ============================================================================
// tb_shift_operand_ctrl: bench for shift_operand_ctrl with RS_LAT=1 and 3.
// Revision 1.0
// ============================================================================
module tb_shift_operand_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_imm = 1'b0;
    logic [11:0] req_operand = 12'd0;
    logic [31:0] req_rm_data = 32'd0;
    logic        req_carry_in = 1'b0;
    logic        rsp_ready = 1'b1;
    logic        sel = 1'b0;
    logic [31:0] rf [16];

    always #5 clk = ~clk;

    logic        req_ready1, rs_rd_en1, sh_carry1, sh_co1, rsp_valid1, rsp_carry1;
    logic [3:0]  rs_addr1;
    logic [31:0] rs_rd_data1, sh_data1, sh_out1, rsp_data1;
    logic [7:0]  sh_num1;
    logic [2:0]  sh_op1;
    logic        req_ready3, rs_rd_en3, sh_carry3, sh_co3, rsp_valid3, rsp_carry3;
    logic [3:0]  rs_addr3;
    logic [31:0] rs_rd_data3, sh_data3, sh_out3, rsp_data3;
    logic [7:0]  sh_num3;
    logic [2:0]  sh_op3;

    shift_operand_ctrl #(.RS_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid & ~sel), .req_ready(req_ready1), .req_imm(req_imm),
        .req_operand(req_operand), .req_rm_data(req_rm_data), .req_carry_in(req_carry_in),
        .rs_rd_en(rs_rd_en1), .rs_addr(rs_addr1), .rs_rd_data(rs_rd_data1),
        .sh_data(sh_data1), .sh_num(sh_num1), .sh_op(sh_op1), .sh_carry(sh_carry1),
        .sh_out(sh_out1), .sh_carry_out(sh_co1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_data(rsp_data1), .rsp_carry(rsp_carry1)
    );

    shift_operand_ctrl #(.RS_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid & sel), .req_ready(req_ready3), .req_imm(req_imm),
        .req_operand(req_operand), .req_rm_data(req_rm_data), .req_carry_in(req_carry_in),
        .rs_rd_en(rs_rd_en3), .rs_addr(rs_addr3), .rs_rd_data(rs_rd_data3),
        .sh_data(sh_data3), .sh_num(sh_num3), .sh_op(sh_op3), .sh_carry(sh_carry3),
        .sh_out(sh_out3), .sh_carry_out(sh_co3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready), .rsp_data(rsp_data3), .rsp_carry(rsp_carry3)
    );

    // Barrel shifter model; carry (and reg-form data) at amount 0 is deliberately untrustworthy.
    function automatic logic [32:0] shf(input logic [31:0] d, input logic [7:0] n,
                                        input logic [2:0] op, input logic c);
        int          k;
        logic [63:0] dd;
        k = int'(n);
        case (op[2:1])
            2'b00: begin
                if (k == 0) return op[0] ? {~c, ~d} : {~c, d};
                if (k < 32) return {d[32-k], d << k};
                if (k == 32) return {d[0], 32'h0};
                return 33'h0;
            end
            2'b01: begin
                if (k == 0 && op[0]) return {~c, ~d};
                if (k == 0) k = 32;
                if (k < 32) return {d[k-1], d >> k};
                if (k == 32) return {d[31], 32'h0};
                return 33'h0;
            end
            2'b10: begin
                if (k == 0 && op[0]) return {~c, ~d};
                if (k == 0 || k >= 32) return {d[31], {32{d[31]}}};
                return {d[k-1], 32'($signed(d) >>> k)};
            end
            default: begin
                if (k == 0 && !op[0]) return {d[0], c, d[31:1]};
                if (k == 0) return {~c, d};
                dd = {d, d} >> (k % 32);
                return {dd[31], dd[31:0]};
            end
        endcase
    endfunction

    assign {sh_co1, sh_out1} = shf(sh_data1, sh_num1, sh_op1, sh_carry1);
    assign {sh_co3, sh_out3} = shf(sh_data3, sh_num3, sh_op3, sh_carry3);

    // Register-file read ports; poison value whenever the read data is not valid.
    logic [31:0] p1_d;
    logic        p1_v = 1'b0;
    logic [31:0] p3_d [3];
    logic [2:0]  p3_v = 3'b0;
    always @(posedge clk) begin
        p1_v    <= rs_rd_en1;
        p1_d    <= rf[rs_addr1];
        p3_v    <= {p3_v[1:0], rs_rd_en3};
        p3_d[0] <= rf[rs_addr3];
        p3_d[1] <= p3_d[0];
        p3_d[2] <= p3_d[1];
    end
    assign rs_rd_data1 = p1_v ? p1_d : 32'hDEADBEEF;
    assign rs_rd_data3 = p3_v[2] ? p3_d[2] : 32'hDEADBEEF;

    logic        m_req_ready, m_rs_rd_en, m_rsp_valid, m_rsp_carry;
    logic [31:0] m_rsp_data;
    logic [7:0]  m_sh_num;
    logic [2:0]  m_sh_op;
    logic [3:0]  m_rs_addr;
    assign m_req_ready = sel ? req_ready3 : req_ready1;
    assign m_rs_rd_en  = sel ? rs_rd_en3  : rs_rd_en1;
    assign m_rsp_valid = sel ? rsp_valid3 : rsp_valid1;
    assign m_rsp_carry = sel ? rsp_carry3 : rsp_carry1;
    assign m_rsp_data  = sel ? rsp_data3  : rsp_data1;
    assign m_sh_num    = sel ? sh_num3    : sh_num1;
    assign m_sh_op     = sel ? sh_op3     : sh_op1;
    assign m_rs_addr   = sel ? rs_addr3   : rs_addr1;

    typedef struct {
        logic        imm;
        logic [11:0] op;
        logic [31:0] rm;
        logic [31:0] rs;
        logic        cin;
        logic [31:0] ed;
        logic        ec;
        logic [7:0]  en;
        logic [2:0]  eo;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic        c;
    } exp_t;

    vec_t tbl [13];
    exp_t sb [$];
    int   n_tests = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(negedge clk);
            if (m_rsp_valid) lat = k;
        end
    endtask

    task automatic run_vec(input vec_t v);
        exp_t        e;
        int          lat;
        int          rd_cnt;
        logic [7:0]  num_s;
        logic [2:0]  op_s;
        logic [3:0]  addr_s;
        logic        erd;
        erd = !v.imm && v.op[4];
        rf[v.op[11:8]] = v.rs;
        e.d = v.ed;
        e.c = v.ec;
        sb.push_back(e);
        req_imm = v.imm; req_operand = v.op; req_rm_data = v.rm; req_carry_in = v.cin;
        req_valid = 1'b1;
        @(negedge clk);
        check("req_ready", 32'(m_req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_operand = ~v.op; req_rm_data = 32'h5A5A5A5A; req_carry_in = ~v.cin;
        lat = 0; rd_cnt = 0; addr_s = 4'd0; num_s = 8'd0; op_s = 3'd0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(negedge clk);
            if (m_rsp_valid) begin
                lat = k;
            end else begin
                num_s = m_sh_num;
                op_s  = m_sh_op;
                if (m_rs_rd_en) begin
                    rd_cnt++;
                    addr_s = m_rs_addr;
                end
            end
        end
        e = sb.pop_front();
        check($sformatf("latency op=%h", v.op), 32'(lat), 32'(v.lat));
        check($sformatf("rsp_data op=%h", v.op), m_rsp_data, e.d);
        check($sformatf("rsp_carry op=%h", v.op), 32'(m_rsp_carry), 32'(e.c));
        check($sformatf("sh_num op=%h", v.op), 32'(num_s), 32'(v.en));
        check($sformatf("sh_op op=%h", v.op), 32'(op_s), 32'(v.eo));
        check($sformatf("rs_rd_en count op=%h", v.op), 32'(rd_cnt), erd ? 32'd1 : 32'd0);
        check($sformatf("rs_addr op=%h", v.op), 32'(addr_s), erd ? 32'(v.op[11:8]) : 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   lat;
        int   seen;
        vec_t v;

        for (int i = 0; i < 16; i++) rf[i] = 32'd0;
        tbl[0]  = '{1'b1, 12'h4FF, 32'h0,        32'h0,   1'b0, 32'hFF000000, 1'b1, 8'd8,  3'b111, 2};
        tbl[1]  = '{1'b0, 12'h020, 32'h80000001, 32'h0,   1'b0, 32'h00000000, 1'b1, 8'd0,  3'b010, 2};
        tbl[2]  = '{1'b0, 12'h040, 32'h80000001, 32'h0,   1'b0, 32'hFFFFFFFF, 1'b1, 8'd0,  3'b100, 2};
        tbl[3]  = '{1'b0, 12'h000, 32'h12345678, 32'h0,   1'b1, 32'h12345678, 1'b1, 8'd0,  3'b000, 2};
        tbl[4]  = '{1'b1, 12'h0AB, 32'h0,        32'h0,   1'b1, 32'h000000AB, 1'b1, 8'd0,  3'b111, 2};
        tbl[5]  = '{1'b0, 12'h200, 32'hF0000001, 32'h0,   1'b0, 32'h00000010, 1'b1, 8'd4,  3'b000, 2};
        tbl[6]  = '{1'b0, 12'h460, 32'h000000AB, 32'h0,   1'b0, 32'hAB000000, 1'b1, 8'd8,  3'b110, 2};
        tbl[7]  = '{1'b0, 12'h060, 32'h00000003, 32'h0,   1'b1, 32'h80000001, 1'b1, 8'd0,  3'b110, 2};
        tbl[8]  = '{1'b0, 12'h376, 32'h80000001, 32'h40,  1'b0, 32'h80000001, 1'b1, 8'd32, 3'b111, 4};
        tbl[9]  = '{1'b0, 12'h210, 32'h12345678, 32'h100, 1'b1, 32'h12345678, 1'b1, 8'd0,  3'b001, 4};
        tbl[10] = '{1'b0, 12'h530, 32'h80000018, 32'h4,   1'b0, 32'h08000001, 1'b1, 8'd4,  3'b011, 4};
        tbl[11] = '{1'b0, 12'h650, 32'h80000000, 32'h28,  1'b0, 32'hFFFFFFFF, 1'b1, 8'd40, 3'b101, 4};
        tbl[12] = '{1'b0, 12'h770, 32'h0000001F, 32'h24,  1'b0, 32'hF0000001, 1'b1, 8'd36, 3'b111, 4};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset req_ready", 32'({req_ready1, req_ready3}), 32'd0);
        check("reset ctrl outputs",
              32'({rsp_valid1, rs_rd_en1, rsp_carry1, sh_carry1, rs_addr1, sh_op1, sh_num1}), 32'd0);
        check("reset rsp_data", rsp_data1, 32'd0);
        check("reset sh_data", sh_data1, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++) run_vec(tbl[i]);

        // Backpressure: held response, second request waits until after the handshake edge
        rsp_ready = 1'b0;
        e.d = 32'hFF000000; e.c = 1'b1; sb.push_back(e);
        req_imm = 1'b1; req_operand = 12'h4FF; req_carry_in = 1'b0; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_operand = 12'h0AB; req_carry_in = 1'b1;
        wait_rsp(lat);
        check("bp first latency", 32'(lat), 32'd2);
        e = sb.pop_front();
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            check("bp rsp_data stable", rsp_data1, e.d);
            check("bp rsp_carry stable", 32'(rsp_carry1), 32'(e.c));
            check("bp req_ready", 32'({rsp_valid1, req_ready1}), 32'b10);
        end
        rsp_ready = 1'b1;
        e.d = 32'h000000AB; e.c = 1'b1; sb.push_back(e);
        @(negedge clk);
        check("bp after handshake", 32'({rsp_valid1, req_ready1}), 32'b01);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wait_rsp(lat);
        e = sb.pop_front();
        check("bp second latency", 32'(lat), 32'd2);
        check("bp second rsp_data", rsp_data1, e.d);
        check("bp second rsp_carry", 32'(rsp_carry1), 32'(e.c));
        @(posedge clk);
        #1;

        // flush in IDLE blocks acceptance
        req_imm = 1'b1; req_operand = 12'h4FF; req_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        check("flush idle no accept", 32'({rsp_valid1, req_ready1}), 32'b01);
        @(posedge clk);
        #1;

        // RS_LAT=3: flush while waiting on Rs
        sel = 1'b1;
        rf[3] = 32'h40;
        req_imm = 1'b0; req_operand = 12'h376; req_rm_data = 32'h80000001; req_carry_in = 1'b0;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("lat3 rs_rd_en strobe", 32'({m_rs_rd_en, m_rs_addr}), 32'h13);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        check("lat3 rs_rd_en off in wait", 32'(m_rs_rd_en), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("after flush", 32'({m_rsp_valid, m_rs_rd_en, m_req_ready}), 32'b001);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (m_rsp_valid || m_rs_rd_en) seen++;
        end
        check("flushed op stays quiet", 32'(seen), 32'd0);
        @(posedge clk);
        #1;
        v = '{1'b0, 12'h376, 32'h80000001, 32'h40, 1'b0, 32'h80000001, 1'b1, 8'd32, 3'b111, 6};
        run_vec(v);
        sel = 1'b0;

        // Reset during SHIFT
        req_imm = 1'b1; req_operand = 12'h4FF; req_carry_in = 1'b0; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst in shift ready", 32'(req_ready1), 32'd0);
        check("rst in shift outputs",
              32'({rsp_valid1, rs_rd_en1, rsp_carry1, sh_carry1, rs_addr1, sh_op1, sh_num1}), 32'd0);
        check("rst in shift rsp_data", rsp_data1, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("after rst release", 32'({rsp_valid1, req_ready1}), 32'b01);
        @(posedge clk);
        #1;
        run_vec(tbl[0]);
        run_vec(tbl[8]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
